// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory read port, branch redirect and decode handshake.
// The master modport is the fetch queue's view; the slave modport is the memory/decode/EX view.
interface mips32_fetch_queue_if #(
    parameter int PC_W = 10
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_ir;
    logic [31:0]     if_npc;
    logic            fetch_halted;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_ir,
        output if_npc,
        output fetch_halted
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_ir,
        input  if_npc,
        input  fetch_halted
    );
endinterface

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch with a DEPTH-entry prefetch FIFO, redirect flush and HLT self-stop.
// Latency: issue at t, head valid at t+2; redirect at t, head valid at t+3. Throughput 1 instr/cycle.
// Backpressure: if_ready low holds the head; issue is credit-gated so the FIFO never overflows.
// Optional FETCH_STATS_EN adds saturating push and flush counters.
module mips32_fetch_queue #(
    parameter int              PC_W     = 10,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       i_clk1,
    input  logic                       i_rst,
    mips32_fetch_queue_if.master       fq
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]                o_stat_fetched,
    output logic [15:0]                o_stat_flushed
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [5:0]  OP_HLT  = 6'b111111;

    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir  [DEPTH];
    logic [PC_W:0]   r_npc [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_inflight;
    logic [PC_W-1:0] r_inflight_addr;
    logic            r_halted;

    logic [CW:0]     w_used;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_is_hlt;
    logic [PC_W:0]   w_cap_npc;

    // Credits count both queued words and the read still on its way back.
    assign w_used    = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign w_issue   = !i_rst && !fq.redirect && !r_halted && (w_used < DEPTH_L);
    assign w_push    = !i_rst && !fq.redirect && r_inflight;
    assign w_pop     = !i_rst && !fq.redirect && (r_count != '0) && fq.if_ready;
    assign w_is_hlt  = (fq.imem_rdata[31:26] == OP_HLT);
    assign w_cap_npc = {1'b0, r_inflight_addr} + 1'b1;

    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_pc            <= RESET_PC;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_halted        <= 1'b0;
        end else if (fq.redirect) begin
            r_pc       <= fq.redirect_pc;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc            <= r_pc + 1'b1;
                r_inflight_addr <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_is_hlt) begin
                    r_halted <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge i_clk1) begin
        if (w_push) begin
            r_ir[r_wr_ptr]  <= fq.imem_rdata;
            r_npc[r_wr_ptr] <= w_cap_npc;
        end
    end

    assign fq.imem_req     = w_issue;
    assign fq.imem_addr    = r_pc;
    assign fq.if_valid     = (r_count != '0);
    assign fq.if_ir        = r_ir[r_rd_ptr];
    assign fq.if_npc       = 32'(r_npc[r_rd_ptr]);
    assign fq.fetch_halted = r_halted;

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [15:0] r_stat_flushed;
    logic [16:0] w_flush_sum;

    assign w_flush_sum = {1'b0, r_stat_flushed} + 17'(w_used);

    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_stat_fetched <= '0;
            r_stat_flushed <= '0;
        end else begin
            if (w_push && (r_stat_fetched != '1)) begin
                r_stat_fetched <= r_stat_fetched + 1'b1;
            end
            if (fq.redirect) begin
                r_stat_flushed <= w_flush_sum[16] ? '1 : w_flush_sum[15:0];
            end
        end
    end

    assign o_stat_fetched = r_stat_fetched;
    assign o_stat_flushed = r_stat_flushed;
`endif
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: directed scenarios plus random traffic against a queue-level model.
module tb_mips32_fetch_queue;
    localparam int PC_W  = 10;
    localparam int DEPTH = 4;
    localparam int MSZ   = 1 << PC_W;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mips32_fetch_queue_if #(.PC_W(PC_W)) fq_if ();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [15:0] stat_flushed;
`endif

    mips32_fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .i_clk1         (clk1),
        .i_rst          (rst),
        .fq             (fq_if)
`ifdef FETCH_STATS_EN
        ,
        .o_stat_fetched (stat_fetched),
        .o_stat_flushed (stat_flushed)
`endif
    );

    logic [31:0] mem [MSZ];

    // Synchronous memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk1)
        fq_if.imem_rdata <= fq_if.imem_req ? mem[fq_if.imem_addr] : $urandom();

    typedef struct {
        logic [31:0] ir;
        int          npc;
    } ent_t;

    ent_t    m_q[$];
    int      m_pc;
    bit      m_inf;
    int      m_inf_addr;
    bit      m_halt;
    longint  m_fetched;
    longint  m_flushed;

    int n_checks = 0;
    int n_errors = 0;

    bit          last_req;
    int          last_addr;
    bit          last_valid;
    bit          last_pop;
    int          last_npc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit rd, input int rpc, input bit rdy);
        bit   exp_req;
        ent_t e;
        rst               = r;
        fq_if.redirect    = rd;
        fq_if.redirect_pc = rpc[PC_W-1:0];
        fq_if.if_ready    = rdy;
        @(negedge clk1);
        exp_req = !r && !rd && !m_halt && ((m_q.size() + int'(m_inf)) < DEPTH);
        chk("imem_req", fq_if.imem_req, exp_req);
        if (exp_req) chk("imem_addr", fq_if.imem_addr, m_pc);
        chk("if_valid", fq_if.if_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("if_ir", fq_if.if_ir, m_q[0].ir);
            chk("if_npc", fq_if.if_npc, m_q[0].npc);
        end
        chk("fetch_halted", fq_if.fetch_halted, m_halt);
        last_req   = fq_if.imem_req;
        last_addr  = int'(fq_if.imem_addr);
        last_valid = fq_if.if_valid;
        last_pop   = fq_if.if_valid && rdy && !rd && !r;
        last_npc   = int'(fq_if.if_npc);
        if (r) begin
            m_q.delete();
            m_pc = 0; m_inf = 0; m_halt = 0; m_fetched = 0; m_flushed = 0;
        end else if (rd) begin
            m_flushed += m_q.size() + int'(m_inf);
            m_q.delete();
            m_inf = 0; m_halt = 0; m_pc = rpc;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (m_inf) begin
                e.ir  = mem[m_inf_addr];
                e.npc = m_inf_addr + 1;
                m_q.push_back(e);
                m_fetched++;
                if (e.ir[31:26] == 6'b111111) m_halt = 1;
            end
            m_inf = exp_req;
            if (exp_req) begin
                m_inf_addr = m_pc;
                m_pc = (m_pc + 1) % MSZ;
            end
        end
        @(posedge clk1);
        #1;
    endtask

    initial begin
        int cnt;
        bit flag_a, flag_b;
        longint fl_before;
        logic [31:0] w;

        fq_if.redirect    = 1'b0;
        fq_if.redirect_pc = '0;
        fq_if.if_ready    = 1'b0;
        for (int i = 0; i < MSZ; i++) begin
            w = $urandom();
            if (w[31:26] == 6'b111111) w[31] = 1'b0;
            mem[i] = w;
        end
        mem[0]    = 32'h0043_0820;  // ADD
        mem[1]    = 32'h0043_0822;  // SUB
        mem[2]    = 32'h0043_0825;  // OR
        mem[3]    = 32'h0043_0824;  // AND
        mem[5]    = 32'hFC00_0000;  // HLT
        mem[MSZ-1] = 32'hFC00_0000;

        // Reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_valid", fq_if.if_valid, 1'b0);
        chk("rst_halted", fq_if.fetch_halted, 1'b0);

        // T1: head appears 2 cycles after reset release
        step(0, 0, 0, 1);
        chk("t1_c0_valid", last_valid, 1'b0);
        chk("t1_c0_addr", last_addr, 0);
        step(0, 0, 0, 1);
        chk("t1_c1_valid", last_valid, 1'b0);
        step(0, 0, 0, 1);
        chk("t1_c2_valid", last_valid, 1'b1);
        chk("t1_c2_npc", last_npc, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // T2: decode stalled for 10 cycles
        step(0, 1, 100, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            cnt += int'(last_req);
        end
        chk("t2_issue_count", cnt, 4);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

        // T3: flush with 3 queued plus 1 in flight
        step(0, 1, 200, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        fl_before = m_flushed;
        step(0, 1, 20, 0);
`ifdef FETCH_STATS_EN
        chk("t6_flushed", stat_flushed, fl_before + 4);
        chk("t6_fetched", stat_fetched, m_fetched);
`endif
        step(0, 0, 0, 0);
        chk("t3_c1_valid", last_valid, 1'b0);
        step(0, 0, 0, 0);
        chk("t3_c2_valid", last_valid, 1'b0);
        step(0, 0, 0, 1);
        chk("t3_c3_valid", last_valid, 1'b1);
        chk("t3_c3_npc", last_npc, 21);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // T4: HLT at address 5 stops fetch, redirect resumes
        step(0, 1, 0, 1);
        flag_a = 0;
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 1);
            if (last_req && last_addr >= 7) flag_a = 1;
        end
        chk("t4_no_addr_ge7", flag_a, 1'b0);
        chk("t4_halted", fq_if.fetch_halted, 1'b1);
        chk("t4_drained", fq_if.if_valid, 1'b0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        chk("t4_resume_req", last_req, 1'b1);
        chk("t4_resume_addr", last_addr, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, MSZ - 1)), $urandom_range(0, 3) != 0);
        end

        // T5: PC wrap and HLT at the top address
        step(0, 1, MSZ - 4, 1);
        flag_a = 0;
        flag_b = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1);
            if (last_req && last_addr == 0) flag_a = 1;
            if (last_pop && last_npc == MSZ) flag_b = 1;
        end
        chk("t5_wrap_addr0", flag_a, 1'b1);
        chk("t5_npc_1024", flag_b, 1'b1);
        chk("t5_halted", fq_if.fetch_halted, 1'b1);

`ifdef FETCH_STATS_EN
        chk("stat_fetched_end", stat_fetched, m_fetched);
        chk("stat_flushed_end", stat_flushed, m_flushed);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
